data_bus_demux: RTL and testbench

DATA_BUS_DEMUX -- requirements
Module: data_bus_demux

---
 rtl/data_bus_demux.sv | 124 ++++++++++++
 tb/tb_data_bus_demux.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_demux.sv
// data_bus_demux: single-outstanding master-to-four-slave bus demux with ack timeout
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   m_req_i/m_we_i            master request strobe and store/load select
//   m_addr_i/m_wdata_i        master address (top two bits pick the slave) and store data
//   m_ready_o                 idle, a request will be accepted on the next edge
//   m_rvalid_o                one-cycle response pulse qualifying m_rdata_o/m_err_o
//   m_rdata_o/m_err_o         load data (0 for stores/timeouts) and timeout flag
//   s_req_o                   one-hot request to slaves 0..3, high only while busy
//   s_we_o/s_addr_o/s_wdata_o latched transaction copy shared by all slaves
//   s_ack_i                   per-slave completion strobes
//   s_rdata0_i..s_rdata3_i    per-slave read data
module data_bus_demux #(
    parameter int TIMEOUT = 15,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m_req_i,
    input  logic          m_we_i,
    input  logic [DW-1:0] m_addr_i,
    input  logic [DW-1:0] m_wdata_i,
    output logic          m_ready_o,
    output logic          m_rvalid_o,
    output logic [DW-1:0] m_rdata_o,
    output logic          m_err_o,
    output logic [3:0]    s_req_o,
    output logic          s_we_o,
    output logic [DW-1:0] s_addr_o,
    output logic [DW-1:0] s_wdata_o,
    input  logic [3:0]    s_ack_i,
    input  logic [DW-1:0] s_rdata0_i,
    input  logic [DW-1:0] s_rdata1_i,
    input  logic [DW-1:0] s_rdata2_i,
    input  logic [DW-1:0] s_rdata3_i
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [7:0] TO   = 8'(TIMEOUT);

    logic [1:0]    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d, cnt_inc;
    logic          s_we_q, s_we_d;
    logic [DW-1:0] s_addr_q, s_addr_d;
    logic [DW-1:0] s_wdata_q, s_wdata_d;
    logic [DW-1:0] m_rdata_q, m_rdata_d;
    logic          m_err_q, m_err_d;
    logic [1:0]    sel;
    logic          ack;
    logic [DW-1:0] sel_rdata;

    // The latched address only changes on acceptance, so the slave select can
    // be derived from it rather than kept in a separate register.
    assign sel       = s_addr_q[DW-1 -: 2];
    assign ack       = s_ack_i[sel];
    assign sel_rdata = sel == 2'd0 ? s_rdata0_i :
                       sel == 2'd1 ? s_rdata1_i :
                       sel == 2'd2 ? s_rdata2_i : s_rdata3_i;
    assign cnt_inc   = cnt_q == TO ? cnt_q : cnt_q + 8'd1;

    assign m_ready_o  = state_q == IDLE;
    assign m_rvalid_o = state_q == RESP;
    assign s_req_o    = state_q == BUSY ? 4'b0001 << sel : 4'b0000;
    assign m_rdata_o  = m_rdata_q;
    assign m_err_o    = m_err_q;
    assign s_we_o     = s_we_q;
    assign s_addr_o   = s_addr_q;
    assign s_wdata_o  = s_wdata_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        m_rdata_d = m_rdata_q;
        m_err_d   = m_err_q;
        case (state_q)
            IDLE: if (m_req_i) begin
                s_we_d    = m_we_i;
                s_addr_d  = m_addr_i;
                s_wdata_d = m_wdata_i;
                cnt_d     = 8'd0;
                state_d   = BUSY;
            end
            // Ack is checked first so it wins over a coinciding timeout.
            BUSY: if (ack) begin
                m_rdata_d = s_we_q ? '0 : sel_rdata;
                m_err_d   = 1'b0;
                state_d   = RESP;
            end else begin
                cnt_d = cnt_inc;
                if (cnt_inc == TO) begin
                    m_rdata_d = '0;
                    m_err_d   = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            m_rdata_q <= '0;
            m_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            m_rdata_q <= m_rdata_d;
            m_err_q   <= m_err_d;
        end
    end
endmodule

// File: tb/tb_data_bus_demux.sv
// tb_data_bus_demux: table-driven scoreboard bench for data_bus_demux
module tb_data_bus_demux;
    logic        clk = 1'b0;
    logic        rst;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic        m_ready_o, m_rvalid_o, m_err_o, s_we_o;
    logic [31:0] m_rdata_o, s_addr_o, s_wdata_o;
    logic [3:0]  s_req_o, s_ack;
    logic [31:0] rdata [4];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          dly;
        logic [3:0]  noise;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    vec_t tv [7];
    exp_t sb [$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    data_bus_demux dut (
        .clk       (clk),
        .rst       (rst),
        .m_req_i   (m_req),
        .m_we_i    (m_we),
        .m_addr_i  (m_addr),
        .m_wdata_i (m_wdata),
        .m_ready_o (m_ready_o),
        .m_rvalid_o(m_rvalid_o),
        .m_rdata_o (m_rdata_o),
        .m_err_o   (m_err_o),
        .s_req_o   (s_req_o),
        .s_we_o    (s_we_o),
        .s_addr_o  (s_addr_o),
        .s_wdata_o (s_wdata_o),
        .s_ack_i   (s_ack),
        .s_rdata0_i(rdata[0]),
        .s_rdata1_i(rdata[1]),
        .s_rdata2_i(rdata[2]),
        .s_rdata3_i(rdata[3])
    );

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic take(input int lat, input bit check_lat);
        exp_t e;
        if (sb.size() == 0) begin
            chk("unexpected_rvalid", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("m_rdata", m_rdata_o, e.rdata);
            chk("m_err", m_err_o, e.err);
            if (check_lat) chk("latency", lat, e.lat);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run(input vec_t v);
        logic [1:0] sel;
        exp_t       e;
        bit         got;
        sel = v.addr[31:30];
        for (int i = 0; i < 4; i++) rdata[i] = 32'h5A5A_0000 | 32'(i);
        rdata[sel] = v.rd;
        chk("ready_before", m_ready_o, 1);
        m_req   = 1'b1;
        m_we    = v.we;
        m_addr  = v.addr;
        m_wdata = v.wdata;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        e.lat   = v.exp_lat;
        sb.push_back(e);
        got = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            m_req   = 1'b0;
            m_we    = ~v.we;
            m_addr  = ~v.addr;
            m_wdata = ~v.wdata;
            s_ack   = 4'b0000;
            if (m_rvalid_o) begin
                got = 1'b1;
                take(c, 1'b1);
            end else begin
                if (c == 1) begin
                    chk("s_we", s_we_o, v.we);
                    chk("s_addr", s_addr_o, v.addr);
                    chk("s_wdata", s_wdata_o, v.wdata);
                end
                chk("s_req_busy", s_req_o, 4'b0001 << sel);
                chk("m_ready_busy", m_ready_o, 0);
                s_ack = (c - 1 == v.dly) ? 4'b0001 << sel : v.noise;
            end
        end
        if (!got) chk("response_timeout", 0, 1);
        @(negedge clk);
        chk("rvalid_one_cycle", m_rvalid_o, 0);
        chk("ready_after", m_ready_o, 1);
        chk("s_req_idle", s_req_o, 0);
        chk("m_rdata_hold", m_rdata_o, v.exp_rdata);
        chk("m_err_hold", m_err_o, v.exp_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        exp_t        e;
        int          acc, rsp;
        //       we    addr           wdata          rd             dly noise    exp_rdata      err  lat
        tv[0] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 3,  4'b0000, 32'hDEAD_BEEF, 1'b0, 5};
        tv[1] = '{1'b1, 32'h0000_0004, 32'h1234_5678, 32'hAAAA_5555, 0,  4'b0000, 32'h0000_0000, 1'b0, 2};
        tv[2] = '{1'b0, 32'hC000_0000, 32'h0000_0000, 32'h7777_7777, -1, 4'b0111, 32'h0000_0000, 1'b1, 16};
        tv[3] = '{1'b0, 32'h4000_0020, 32'h0000_0000, 32'h0BAD_F00D, 4,  4'b0101, 32'h0BAD_F00D, 1'b0, 6};
        tv[4] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 32'h1111_2222, 14, 4'b1110, 32'h1111_2222, 1'b0, 16};
        tv[5] = '{1'b1, 32'h8000_0000, 32'hFACE_0FF0, 32'h3333_4444, -1, 4'b1011, 32'h0000_0000, 1'b1, 16};
        tv[6] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'hCAFE_BABE, 1,  4'b0000, 32'hCAFE_BABE, 1'b0, 3};
        rst = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; s_ack = '0;
        for (int i = 0; i < 4; i++) rdata[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_m_ready", m_ready_o, 1);
        chk("rst_m_rvalid", m_rvalid_o, 0);
        chk("rst_s_req", s_req_o, 0);
        chk("rst_m_err", m_err_o, 0);
        chk("rst_m_rdata", m_rdata_o, 0);
        chk("rst_s_bus", {s_we_o, s_addr_o, s_wdata_o}, 0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) run(tv[i]);
        // Back-pressure: m_req held high with a new address each cycle.
        for (int i = 0; i < 4; i++) rdata[i] = 32'hB000_0000 | 32'(i);
        acc = 0; rsp = 0;
        m_we = 1'b0; m_req = 1'b1;
        for (int k = 0; k < 24; k++) begin
            a = {2'(k), 30'(k)};
            m_addr = a;
            if (m_ready_o) begin
                e.rdata = 32'hB000_0000 | 32'(a[31:30]);
                e.err   = 1'b0;
                e.lat   = 0;
                sb.push_back(e);
                acc++;
            end
            s_ack = m_ready_o ? 4'b1111 : s_req_o;
            @(negedge clk);
            if (m_rvalid_o) begin
                rsp++;
                take(0, 1'b0);
            end
        end
        m_req = 1'b0; s_ack = '0;
        repeat (4) begin
            @(negedge clk);
            if (m_rvalid_o) begin
                rsp++;
                take(0, 1'b0);
            end
        end
        chk("bp_responses", rsp, acc);
        chk("bp_accepted", acc, 8);
        chk("bp_sb_empty", sb.size(), 0);
        // Reset between edges while a transaction is outstanding.
        rdata[1] = 32'h0000_1111;
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h4000_0000;
        @(negedge clk);
        m_req = 1'b0;
        chk("mid_s_req", s_req_o, 4'b0010);
        #2 rst = 1'b1;
        #1;
        chk("async_s_req", s_req_o, 0);
        chk("async_m_ready", m_ready_o, 1);
        chk("async_m_rdata", m_rdata_o, 0);
        chk("async_s_addr", s_addr_o, 0);
        s_ack = 4'b0010;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_rvalid", m_rvalid_o, 0);
            chk("post_rst_s_req", s_req_o, 0);
            s_ack = '0;
        end
        run(tv[0]);
        run(tv[1]);
        chk("final_sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
